// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction,
// drives datapath controls from the latched opcode and counts retired instructions.
module multicycle_sequencer #(
  parameter int COUNT_W = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        Instruction,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               Zero,
  output logic               imem_req,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               Branch,
  output logic [1:0]         ALUOp,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic [2:0]         state,
  output logic               busy,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t               state_reg, state_next;
  logic [6:0]           opcode_reg, opcode_next;
  logic [COUNT_W-1:0]   count_reg, count_next;
  logic                 illegal_reg, illegal_next;
  logic                 retire;
  logic                 is_r, is_ld, is_sd, is_beq, op_known;

  // Only the opcode field steers the sequence; the rest of the word belongs to the datapath.
  logic instr_unused;
  assign instr_unused = ^Instruction[31:7];

  assign is_r     = (opcode_reg == OP_R);
  assign is_ld    = (opcode_reg == OP_LD);
  assign is_sd    = (opcode_reg == OP_SD);
  assign is_beq   = (opcode_reg == OP_BEQ);
  assign op_known = is_r | is_ld | is_sd | is_beq;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= S_IDLE;
      opcode_reg  <= 7'd0;
      count_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      opcode_reg  <= opcode_next;
      count_reg   <= count_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    count_next   = count_reg;
    illegal_next = illegal_reg;
    retire       = 1'b0;
    imem_req     = 1'b0;
    IRWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    Branch       = 1'b0;
    ALUOp        = 2'b00;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && !stop) state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite     = 1'b1;
          opcode_next = Instruction[6:0];
          state_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_known) begin
          state_next = S_EXECUTE;
        end else begin
          state_next   = S_HALT;
          illegal_next = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (is_r) begin
          ALUOp      = 2'b10;
          state_next = S_WRITEBACK;
        end else if (is_beq) begin
          ALUOp   = 2'b01;
          Branch  = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = Zero;
          retire  = 1'b1;
        end else if (is_ld || is_sd) begin
          ALUSrc     = 1'b1;
          state_next = S_MEM;
        end else begin
          state_next   = S_HALT;
          illegal_next = 1'b1;
        end
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = is_ld;
        MemWrite = is_sd;
        // Stores complete on the data handshake; loads still need the register write.
        if (dmem_ready) begin
          if (is_sd) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
          end else begin
            state_next = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        RegWrite = 1'b1;
        MemtoReg = is_ld;
        PCWrite  = 1'b1;
        retire   = 1'b1;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (retire) begin
      count_next = count_reg + COUNT_W'(1);
      state_next = stop ? S_IDLE : S_FETCH;
    end
  end

  assign state       = state_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign illegal     = illegal_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each directed
// instruction into its expected per-cycle control vectors; a compare process checks every cycle.
module tb_multicycle_sequencer;
  localparam int CW = 4;
  localparam logic [31:0] GARBAGE = 32'h0000_0013;

  logic Clk = 1'b0;
  logic Reset, start, stop, imem_ready, dmem_ready, Zero;
  logic [31:0] Instruction;
  logic imem_req, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch;
  logic [1:0] ALUOp;
  logic PCWrite, PCSrc, busy, illegal;
  logic [2:0] state;
  logic [CW-1:0] instr_count;

  multicycle_sequencer #(.COUNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .Instruction(Instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .Zero(Zero),
    .imem_req(imem_req), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Branch(Branch),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .PCSrc(PCSrc), .state(state), .busy(busy),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          imem_req, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write, branch;
    logic [1:0]    alu_op;
    logic          pc_write, pc_src, busy, illegal;
    logic [CW-1:0] count;
  } vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  string lit_name[$];
  int    lit_sel[$];
  int    lit_val[$];

  int tests = 0;
  int fails = 0;
  int m_count = 0;
  bit m_illegal = 1'b0;

  int tot_busy = 0, tot_rw = 0, tot_mr = 0, tot_mw = 0;
  int base_busy = 0, base_rw = 0, base_mr = 0, base_mw = 0;
  vec_t got, want;
  string nm;
  int got_i;

  // Compare process: literal checks first (they refer to cycles already seen), then this cycle's vector.
  always @(negedge Clk) begin
    got = {state, imem_req, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch,
           ALUOp, PCWrite, PCSrc, busy, illegal, instr_count};
    while (lit_sel.size() > 0) begin
      nm = lit_name.pop_front();
      got_i = 0;
      case (lit_sel[0])
        1: got_i = int'(state);
        2: got_i = int'(instr_count);
        3: got_i = int'(illegal);
        4: got_i = tot_busy - base_busy;
        5: got_i = tot_rw - base_rw;
        6: got_i = tot_mr - base_mr;
        7: got_i = tot_mw - base_mw;
        default: begin
          base_busy = tot_busy; base_rw = tot_rw; base_mr = tot_mr; base_mw = tot_mw;
        end
      endcase
      if (lit_sel[0] != 0) begin
        tests++;
        if (got_i != lit_val[0]) begin
          fails++;
          $display("FAIL %s: got %0d want %0d", nm, got_i, lit_val[0]);
        end
      end
      void'(lit_sel.pop_front());
      void'(lit_val.pop_front());
    end
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s: got %h want %h", nm, got, want);
      end
    end
    tot_busy += (busy === 1'b1) ? 1 : 0;
    tot_rw   += (RegWrite === 1'b1) ? 1 : 0;
    tot_mr   += (MemRead === 1'b1) ? 1 : 0;
    tot_mw   += (MemWrite === 1'b1) ? 1 : 0;
  end

  task automatic lit(input string n, input int sel, input int val);
    lit_name.push_back(n);
    lit_sel.push_back(sel);
    lit_val.push_back(val);
  endtask

  function automatic vec_t base(input logic [2:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    v.busy = (st != 3'd0) && (st != 3'd6);
    v.illegal = m_illegal;
    v.count = CW'(m_count);
    return v;
  endfunction

  task automatic step(input vec_t v, input string n, input bit chk, input logic rst, input logic st,
                      input logic sp, input logic ir, input logic dr, input logic z,
                      input logic [31:0] ins);
    Reset = rst; start = st; stop = sp; imem_ready = ir; dmem_ready = dr; Zero = z; Instruction = ins;
    if (chk) begin
      exp_q.push_back(v);
      name_q.push_back(n);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic retire_model();
    m_count = (m_count + 1) % (1 << CW);
  endtask

  task automatic idle(input string n, input int cycles, input logic st, input logic sp);
    for (int i = 0; i < cycles; i++)
      step(base(3'd0), $sformatf("%s/idle%0d", n, i), 1'b1, 1'b0, st, sp, 1'b0, 1'b0, 1'b0, GARBAGE);
  endtask

  // Expands one instruction into expected cycles; entered with the DUT in FETCH.
  task automatic run_instr(input string n, input logic [31:0] ins, input int iw, input int dw,
                           input logic z, input logic sp, input int rst_at);
    logic [6:0] op;
    bit is_r, is_ld, is_sd, is_beq, last;
    vec_t v;
    op = ins[6:0];
    is_r = (op == 7'b0110011); is_ld = (op == 7'b0000011);
    is_sd = (op == 7'b0100011); is_beq = (op == 7'b1100011);
    for (int i = 0; i <= iw; i++) begin
      last = (i == iw);
      v = base(3'd1); v.imem_req = 1'b1; v.ir_write = last;
      step(v, $sformatf("%s/fetch%0d", n, i), 1'b1, 1'b0, 1'b0, sp, last, 1'b0, z, last ? ins : GARBAGE);
    end
    step(base(3'd2), {n, "/decode"}, 1'b1, 1'b0, 1'b0, sp, 1'b0, 1'b0, z, GARBAGE);
    if (!(is_r || is_ld || is_sd || is_beq)) begin
      m_illegal = 1'b1;
      return;
    end
    v = base(3'd3);
    v.alu_op = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
    v.alu_src = is_ld || is_sd;
    if (is_beq) begin v.branch = 1'b1; v.pc_write = 1'b1; v.pc_src = z; end
    step(v, {n, "/execute"}, 1'b1, 1'b0, 1'b0, sp, 1'b0, 1'b0, z, GARBAGE);
    if (is_beq) begin retire_model(); return; end
    if (is_ld || is_sd) begin
      for (int i = 0; i <= dw; i++) begin
        last = (i == dw);
        v = base(3'd4); v.alu_src = 1'b1; v.mem_read = is_ld; v.mem_write = is_sd;
        v.pc_write = is_sd && last;
        step(v, $sformatf("%s/mem%0d", n, i), 1'b1, (i == rst_at), 1'b0, sp, 1'b0, last, z, GARBAGE);
        if (i == rst_at) begin m_count = 0; m_illegal = 1'b0; return; end
      end
      if (is_sd) begin retire_model(); return; end
    end
    v = base(3'd5); v.reg_write = 1'b1; v.mem_to_reg = is_ld; v.pc_write = 1'b1;
    step(v, {n, "/writeback"}, 1'b1, 1'b0, 1'b0, sp, 1'b0, 1'b0, z, GARBAGE);
    retire_model();
  endtask

  initial begin
    step(base(3'd0), "por", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, GARBAGE);
    step(base(3'd0), "reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, GARBAGE);
    lit("reset_state", 1, 0);
    lit("reset_count", 2, 0);
    idle("after_reset", 2, 1'b0, 1'b0);
    idle("start_blocked", 2, 1'b1, 1'b1);
    idle("start", 1, 1'b1, 1'b0);

    lit("mark", 0, 0);
    run_instr("add", 32'h002081B3, 0, 0, 1'b0, 1'b0, -1);
    lit("add_count", 2, 1); lit("add_regwrite", 5, 1); lit("add_cycles", 4, 4);

    lit("mark", 0, 0);
    run_instr("ld", 32'h0080B283, 0, 3, 1'b0, 1'b0, -1);
    lit("ld_cycles", 4, 8); lit("ld_memread", 6, 4); lit("ld_count", 2, 2);

    lit("mark", 0, 0);
    run_instr("sd", 32'h0050B423, 1, 1, 1'b1, 1'b0, -1);
    lit("sd_regwrite", 5, 0); lit("sd_memwrite", 7, 2); lit("sd_count", 2, 3);

    lit("mark", 0, 0);
    run_instr("beq_z1", 32'h00208463, 0, 0, 1'b1, 1'b0, -1);
    lit("beq_z1_cycles", 4, 3);
    lit("mark", 0, 0);
    run_instr("beq_z0", 32'h00208463, 0, 0, 1'b0, 1'b0, -1);
    lit("beq_z0_cycles", 4, 3);

    run_instr("add_stop", 32'h002081B3, 2, 0, 1'b0, 1'b1, -1);
    lit("stop_state", 1, 0); lit("stop_count", 2, 6);
    idle("after_stop", 2, 1'b0, 1'b0);

    idle("restart", 1, 1'b1, 1'b0);
    run_instr("ld_rst", 32'h0080B283, 0, 3, 1'b0, 1'b0, 1);
    lit("rst_mem_state", 1, 0); lit("rst_mem_count", 2, 0);
    idle("after_mem_rst", 2, 1'b1, 1'b1);

    idle("wrap_start", 1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++)
      run_instr($sformatf("wrap%0d", i), 32'h002081B3, i % 3, 0, i[0], (i == 16), -1);
    lit("wrap_count", 2, 1);
    idle("after_wrap", 1, 1'b0, 1'b0);

    idle("ill_start", 1, 1'b1, 1'b0);
    run_instr("illegal", 32'h00000013, 0, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 3; i++)
      step(base(3'd6), $sformatf("halt%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h002081B3);
    lit("halt_state", 1, 6); lit("halt_illegal", 3, 1);
    step(base(3'd6), "halt_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, GARBAGE);
    m_illegal = 1'b0;
    m_count = 0;
    lit("post_halt_state", 1, 0); lit("post_halt_illegal", 3, 0); lit("post_halt_count", 2, 0);
    idle("final", 3, 1'b0, 1'b0);
    step(base(3'd0), "drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, GARBAGE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
